// File: rtl/exec_core_if.sv
// Signal bundle between one TIS-100 execute stage, its instruction ROM and its four neighbours.
// The execute core takes the slave view; ROM and neighbours together take the master view.
interface exec_core_if;
    logic [20:0] instr;
    logic        rom_en;
    logic [3:0]  rom_op;
    logic [10:0] rom_acc;
    logic [10:0] rom_off;
    logic [43:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [10:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;

    modport slave (
        input  instr, in_data, in_valid, out_ready,
        output rom_en, rom_op, rom_acc, rom_off, in_ready, out_data, out_valid
    );
    modport master (
        output instr, in_data, in_valid, out_ready,
        input  rom_en, rom_op, rom_acc, rom_off, in_ready, out_data, out_valid
    );
endinterface

// File: rtl/exec_core.sv
// Execute stage of a TIS-100 node: runs one instruction word against ACC/BAK and the four
// neighbour ports, then pulses rom_en with op/acc/offset so the ROM can pick the next PC.
module exec_core #(
    parameter int ACC_MAX = 999
) (
    input  logic       clk,
    input  logic       reset,
    exec_core_if.slave bus
);
    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    localparam logic [3:0] OP_MOV = 4'd1, OP_SWP = 4'd2, OP_SAV = 4'd3, OP_ADD = 4'd4,
                           OP_SUB = 4'd5, OP_NEG = 4'd6, OP_JMP = 4'd7, OP_JEZ = 4'd8,
                           OP_JNZ = 4'd9, OP_JGZ = 4'd10, OP_JLZ = 4'd11, OP_JRO = 4'd12;

    state_t             r_state;
    logic signed [10:0] r_acc, r_bak;
    logic               r_rom_en;
    logic [3:0]         r_rom_op;
    logic [10:0]        r_rom_acc, r_rom_off, r_out_data;
    logic [3:0]         r_in_ready, r_out_valid;

    logic [3:0]         w_op;
    logic [2:0]         w_src, w_dst;
    logic signed [10:0] w_imm, w_port_raw, w_local_raw, w_raw, w_src_val;
    logic signed [10:0] w_new_acc, w_new_bak, w_new_off;
    logic signed [11:0] w_acc12, w_val12;
    logic [3:0]         w_rd_xfer, w_wr_xfer;
    logic               w_reads_src, w_src_port, w_dst_port, w_retire;

    function automatic logic signed [10:0] clamp_acc(input logic signed [11:0] v);
        logic signed [11:0] lim;
        lim = 12'(ACC_MAX);
        if (v > lim)       clamp_acc = lim[10:0];
        else if (v < -lim) clamp_acc = 11'(-lim);
        else               clamp_acc = v[10:0];
    endfunction

    function automatic logic [3:0] port_mask(input logic [2:0] code);
        case (code)
            3'd2:    port_mask = 4'b0001;
            3'd3:    port_mask = 4'b0010;
            3'd4:    port_mask = 4'b0100;
            3'd5:    port_mask = 4'b1000;
            3'd6:    port_mask = 4'b1111;
            default: port_mask = 4'b0000;
        endcase
    endfunction

    // An offered port is withdrawn while a higher-priority offered port has its peer asserted,
    // so an ANY transfer can only ever complete on a single port.
    function automatic logic [3:0] prio_gate(input logic [3:0] offer, input logic [3:0] peer);
        prio_gate[0] = offer[0];
        prio_gate[1] = offer[1] & ~(offer[0] & peer[0]);
        prio_gate[2] = offer[2] & ~|(offer[1:0] & peer[1:0]);
        prio_gate[3] = offer[3] & ~|(offer[2:0] & peer[2:0]);
    endfunction

    assign w_op        = bus.instr[20:17];
    assign w_src       = bus.instr[16:14];
    assign w_dst       = bus.instr[13:11];
    assign w_imm       = bus.instr[10:0];
    assign w_reads_src = (w_op == OP_MOV) || (w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_JRO);
    assign w_src_port  = w_reads_src && (port_mask(w_src) != 4'b0000);
    assign w_dst_port  = (w_op == OP_MOV) && (port_mask(w_dst) != 4'b0000);

    assign bus.in_ready  = prio_gate(r_in_ready, bus.in_valid);
    assign bus.out_valid = prio_gate(r_out_valid, bus.out_ready);
    assign w_rd_xfer     = bus.in_ready & bus.in_valid;
    assign w_wr_xfer     = bus.out_valid & bus.out_ready;

    // Data of the single port that completed a read this cycle.
    always_comb begin
        if (w_rd_xfer[0])      w_port_raw = bus.in_data[10:0];
        else if (w_rd_xfer[1]) w_port_raw = bus.in_data[21:11];
        else if (w_rd_xfer[2]) w_port_raw = bus.in_data[32:22];
        else if (w_rd_xfer[3]) w_port_raw = bus.in_data[43:33];
        else                   w_port_raw = 11'sd0;
    end

    // Non-port operand: NIL and unused codes read as zero.
    always_comb begin
        case (w_src)
            3'd1:    w_local_raw = r_acc;
            3'd7:    w_local_raw = w_imm;
            default: w_local_raw = 11'sd0;
        endcase
    end

    assign w_raw     = (r_state == ST_READ) ? w_port_raw : w_local_raw;
    assign w_src_val = clamp_acc({w_raw[10], w_raw});
    assign w_acc12   = {r_acc[10], r_acc};
    assign w_val12   = {w_src_val[10], w_src_val};

    // Register values and jump offset produced by the instruction if it retires now.
    always_comb begin
        w_new_acc = r_acc;
        w_new_bak = r_bak;
        w_new_off = 11'sd0;
        case (w_op)
            OP_MOV: begin
                if (w_dst == 3'd1) w_new_acc = w_src_val;
                else               w_new_acc = r_acc;
            end
            OP_SWP: begin
                w_new_acc = r_bak;
                w_new_bak = r_acc;
            end
            OP_SAV:                                 w_new_bak = r_acc;
            OP_ADD:                                 w_new_acc = clamp_acc(w_acc12 + w_val12);
            OP_SUB:                                 w_new_acc = clamp_acc(w_acc12 - w_val12);
            OP_NEG:                                 w_new_acc = -r_acc;
            OP_JMP, OP_JEZ, OP_JNZ, OP_JGZ, OP_JLZ: w_new_off = w_imm;
            OP_JRO:                                 w_new_off = w_src_val;
            default:                                w_new_acc = r_acc;
        endcase
    end

    // Retirement condition for the current state.
    always_comb begin
        case (r_state)
            ST_EXEC:  w_retire = !w_src_port && !w_dst_port;
            ST_READ:  w_retire = (|w_rd_xfer) && !w_dst_port;
            ST_WRITE: w_retire = |w_wr_xfer;
            default:  w_retire = 1'b0;
        endcase
    end

    // Sequencer with registered handshake and ROM-feedback outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_WAIT;
            r_acc       <= 11'sd0;
            r_bak       <= 11'sd0;
            r_rom_en    <= 1'b0;
            r_rom_op    <= 4'd0;
            r_rom_acc   <= 11'd0;
            r_rom_off   <= 11'd0;
            r_in_ready  <= 4'b0000;
            r_out_valid <= 4'b0000;
            r_out_data  <= 11'd0;
        end else begin
            r_rom_en <= 1'b0;
            case (r_state)
                ST_WAIT: r_state <= ST_EXEC;
                ST_EXEC: begin
                    if (w_src_port) begin
                        r_in_ready <= port_mask(w_src);
                        r_state    <= ST_READ;
                    end else if (w_dst_port) begin
                        r_out_data  <= w_src_val;
                        r_out_valid <= port_mask(w_dst);
                        r_state     <= ST_WRITE;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_READ: begin
                    if (|w_rd_xfer) begin
                        r_in_ready <= 4'b0000;
                        if (w_dst_port) begin
                            r_out_data  <= w_src_val;
                            r_out_valid <= port_mask(w_dst);
                            r_state     <= ST_WRITE;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end else begin
                        r_state <= ST_READ;
                    end
                end
                ST_WRITE: begin
                    if (|w_wr_xfer) begin
                        r_out_valid <= 4'b0000;
                        r_state     <= ST_WAIT;
                    end else begin
                        r_state <= ST_WRITE;
                    end
                end
                default: r_state <= ST_WAIT;
            endcase
            if (w_retire) begin
                r_rom_en  <= 1'b1;
                r_rom_op  <= w_op;
                r_rom_acc <= w_new_acc;
                r_rom_off <= w_new_off;
                r_acc     <= w_new_acc;
                r_bak     <= w_new_bak;
            end
        end
    end

    assign bus.rom_en   = r_rom_en;
    assign bus.rom_op   = r_rom_op;
    assign bus.rom_acc  = r_rom_acc;
    assign bus.rom_off  = r_rom_off;
    assign bus.out_data = r_out_data;
endmodule

// File: tb/tb_exec_core.sv
// Self-checking bench for exec_core: the bench plays instruction ROM and neighbours and
// compares retirements against an integer model of the instruction set.
module tb_exec_core;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   m_acc = 0, m_bak = 0, exp_acc = 0, exp_off = 0;

    exec_core_if bus();
    exec_core #(.ACC_MAX(999)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    function automatic int clamp(input int v);
        return (v > 999) ? 999 : ((v < -999) ? -999 : v);
    endfunction

    function automatic int sx11(input logic [10:0] v);
        return int'($signed(v));
    endfunction

    function automatic logic [20:0] mk(input int op, input int src, input int dst, input int imm);
        return {op[3:0], src[2:0], dst[2:0], imm[10:0]};
    endfunction

    function automatic int local_src(input int src, input int imm);
        if (src == 1)      return m_acc;
        else if (src == 7) return clamp(imm);
        else               return 0;
    endfunction

    function automatic void model(input int op, input int dst, input int sv, input int imm);
        int t;
        exp_off = 0;
        case (op)
            1:  if (dst == 1) m_acc = sv;
            2:  begin t = m_acc; m_acc = m_bak; m_bak = t; end
            3:  m_bak = m_acc;
            4:  m_acc = clamp(m_acc + sv);
            5:  m_acc = clamp(m_acc - sv);
            6:  m_acc = -m_acc;
            7, 8, 9, 10, 11: exp_off = imm;
            12: exp_off = sv;
            default: ;
        endcase
        exp_acc = m_acc;
    endfunction

    // Present a word and count cycles until the retirement pulse (bounded).
    task automatic run_instr(input logic [20:0] word, output int cyc);
        bus.instr = word;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (bus.rom_en !== 1'b1 && cyc < 50);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.instr = mk(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.rom_en, bus.rom_op, bus.rom_acc, bus.rom_off} !== 27'd0) begin
            errors++;
            $display("FAIL reset_rom got en=%b op=%0d acc=%0d off=%0d want all 0",
                     bus.rom_en, bus.rom_op, bus.rom_acc, bus.rom_off);
        end
        checks++;
        if (bus.in_ready !== 4'd0 || bus.out_valid !== 4'd0 || bus.out_data !== 11'd0) begin
            errors++;
            $display("FAIL reset_ports got rdy=%b vld=%b data=%0d want 0", bus.in_ready, bus.out_valid, bus.out_data);
        end
        m_acc = 0;
        m_bak = 0;
        reset = 1'b1;
    endtask

    task automatic test_basic();
        int ops [3]  = '{1, 4, 5};
        int srcs [3] = '{7, 7, 1};
        int imms [3] = '{5, 3, 0};
        int want [3] = '{5, 8, 0};
        int cyc, sv;
        for (int i = 0; i < 3; i++) begin
            sv = local_src(srcs[i], imms[i]);
            run_instr(mk(ops[i], srcs[i], 1, imms[i]), cyc);
            model(ops[i], 1, sv, imms[i]);
            checks++;
            if (sx11(bus.rom_acc) !== want[i]) begin
                errors++;
                $display("FAIL basic_acc[%0d] got %0d want %0d", i, sx11(bus.rom_acc), want[i]);
            end
            checks++;
            if (cyc !== 2 || bus.rom_op !== 4'(ops[i])) begin
                errors++;
                $display("FAIL basic_timing[%0d] got cyc=%0d op=%0d want cyc=2 op=%0d", i, cyc, bus.rom_op, ops[i]);
            end
        end
    endtask

    task automatic test_saturate();
        int ops [4]  = '{4, 4, 6, 5};
        int srcs [4] = '{7, 7, 0, 7};
        int imms [4] = '{999, 999, 0, 999};
        int want [4] = '{999, 999, -999, -999};
        int cyc, sv;
        for (int i = 0; i < 4; i++) begin
            sv = local_src(srcs[i], imms[i]);
            run_instr(mk(ops[i], srcs[i], 0, imms[i]), cyc);
            model(ops[i], 0, sv, imms[i]);
            checks++;
            if (sx11(bus.rom_acc) !== want[i] || cyc !== 2) begin
                errors++;
                $display("FAIL saturate[%0d] got acc=%0d cyc=%0d want acc=%0d cyc=2", i, sx11(bus.rom_acc), cyc, want[i]);
            end
        end
    endtask

    task automatic test_random();
        int op, src, dst, simm, sv, cyc;
        int loc [3] = '{0, 1, 7};
        for (int i = 0; i < 40; i++) begin
            op   = int'($urandom_range(15, 0));
            simm = int'($urandom_range(2047, 0)) - 1024;
            if (op == 1 || op == 4 || op == 5 || op == 12) src = loc[$urandom_range(2, 0)];
            else                                           src = int'($urandom_range(7, 0));
            if (op == 1) dst = loc[$urandom_range(2, 0)];
            else         dst = int'($urandom_range(7, 0));
            sv = local_src(src, simm);
            run_instr(mk(op, src, dst, simm), cyc);
            model(op, dst, sv, simm);
            checks++;
            if (cyc !== 2 || bus.rom_op !== 4'(op) || sx11(bus.rom_acc) !== exp_acc) begin
                errors++;
                $display("FAIL random[%0d] op=%0d src=%0d got cyc=%0d op=%0d acc=%0d want cyc=2 acc=%0d",
                         i, op, src, cyc, bus.rom_op, sx11(bus.rom_acc), exp_acc);
            end
            if (op >= 7 && op <= 12) begin
                checks++;
                if (sx11(bus.rom_off) !== exp_off) begin
                    errors++;
                    $display("FAIL random_off[%0d] op=%0d got %0d want %0d", i, op, sx11(bus.rom_off), exp_off);
                end
            end
        end
    endtask

    task automatic test_read();
        bit stall_ok = 1'b1;
        bus.in_valid = 4'b0000;
        bus.instr = mk(1, 2, 1, 0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (bus.in_ready !== 4'b0001 || bus.rom_en !== 1'b0) stall_ok = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (!stall_ok) begin
            errors++;
            $display("FAIL read_stall got rdy=%b en=%b want rdy=0001 en=0 throughout", bus.in_ready, bus.rom_en);
        end
        bus.in_data  = {33'd0, 11'd42};
        bus.in_valid = 4'b0001;
        @(negedge clk);
        bus.in_valid = 4'b0000;
        model(1, 1, 42, 0);
        checks++;
        if (bus.rom_en !== 1'b1 || sx11(bus.rom_acc) !== 42 || bus.in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL read_done got en=%b acc=%0d rdy=%b want en=1 acc=42 rdy=0000",
                     bus.rom_en, sx11(bus.rom_acc), bus.in_ready);
        end
        // ADD ANY with LEFT and RIGHT both offering; LEFT wins and -1024 clamps to -999
        bus.in_data  = {11'd5, 11'h400, 11'd0, 11'd0};
        bus.in_valid = 4'b1100;
        bus.instr = mk(4, 6, 0, 0);
        repeat (2) @(negedge clk);
        checks++;
        if ((bus.in_valid & bus.in_ready) !== 4'b0100) begin
            errors++;
            $display("FAIL read_any_sel got %b want 0100", bus.in_valid & bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 4'b0000;
        model(4, 0, clamp(-1024), 0);
        checks++;
        if (bus.rom_en !== 1'b1 || sx11(bus.rom_acc) !== exp_acc) begin
            errors++;
            $display("FAIL read_any_acc got en=%b acc=%0d want en=1 acc=%0d", bus.rom_en, sx11(bus.rom_acc), exp_acc);
        end
    endtask

    task automatic test_write();
        int  cyc;
        bit  stall_ok = 1'b1;
        run_instr(mk(1, 7, 1, 7), cyc);
        model(1, 1, 7, 7);
        bus.out_ready = 4'b1010;
        bus.instr = mk(1, 1, 6, 0);
        repeat (2) @(negedge clk);
        checks++;
        if ((bus.out_valid & bus.out_ready) !== 4'b0010 || bus.out_data !== 11'd7) begin
            errors++;
            $display("FAIL write_any got xfer=%b data=%0d want xfer=0010 data=7",
                     bus.out_valid & bus.out_ready, bus.out_data);
        end
        @(negedge clk);
        bus.out_ready = 4'b0000;
        checks++;
        if (bus.out_valid !== 4'b0000 || bus.rom_en !== 1'b1 || sx11(bus.rom_acc) !== m_acc) begin
            errors++;
            $display("FAIL write_any_done got vld=%b en=%b acc=%0d want vld=0000 en=1 acc=%0d",
                     bus.out_valid, bus.rom_en, sx11(bus.rom_acc), m_acc);
        end
        bus.instr = mk(1, 7, 5, 1023);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (bus.out_valid !== 4'b1000 || bus.rom_en !== 1'b0) stall_ok = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (!stall_ok || bus.out_data !== 11'd999) begin
            errors++;
            $display("FAIL write_stall got vld=%b en=%b data=%0d want vld=1000 en=0 data=999",
                     bus.out_valid, bus.rom_en, bus.out_data);
        end
        bus.out_ready = 4'b1000;
        @(negedge clk);
        bus.out_ready = 4'b0000;
        checks++;
        if (bus.out_valid !== 4'b0000 || bus.rom_en !== 1'b1) begin
            errors++;
            $display("FAIL write_stall_done got vld=%b en=%b want vld=0000 en=1", bus.out_valid, bus.rom_en);
        end
    endtask

    task automatic test_swap();
        int ops [5]  = '{1, 3, 6, 2, 2};
        int want [5] = '{12, 12, -12, 12, -12};
        int cyc, sv;
        for (int i = 0; i < 5; i++) begin
            sv = local_src(7, 12);
            run_instr(mk(ops[i], 7, 1, 12), cyc);
            model(ops[i], 1, sv, 12);
            checks++;
            if (sx11(bus.rom_acc) !== want[i] || cyc !== 2) begin
                errors++;
                $display("FAIL swap[%0d] got acc=%0d cyc=%0d want acc=%0d cyc=2", i, sx11(bus.rom_acc), cyc, want[i]);
            end
        end
    endtask

    task automatic test_jump_reset();
        int cyc;
        run_instr(mk(12, 7, 0, -3), cyc);
        checks++;
        if (bus.rom_op !== 4'hC || sx11(bus.rom_off) !== -3 || sx11(bus.rom_acc) !== m_acc) begin
            errors++;
            $display("FAIL jro got op=%0d off=%0d acc=%0d want op=12 off=-3 acc=%0d",
                     bus.rom_op, sx11(bus.rom_off), sx11(bus.rom_acc), m_acc);
        end
        bus.out_ready = 4'b0000;
        bus.instr = mk(1, 7, 2, 1);
        repeat (2) @(negedge clk);
        checks++;
        if (bus.out_valid !== 4'b0001) begin
            errors++;
            $display("FAIL pending_write got vld=%b want 0001", bus.out_valid);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 4'b0000 || bus.rom_en !== 1'b0 || bus.in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid got vld=%b en=%b rdy=%b want 0", bus.out_valid, bus.rom_en, bus.in_ready);
        end
        repeat (2) @(negedge clk);
        m_acc = 0;
        m_bak = 0;
        reset = 1'b1;
        run_instr(mk(4, 7, 0, 10), cyc);
        checks++;
        if (cyc !== 2 || sx11(bus.rom_acc) !== 10) begin
            errors++;
            $display("FAIL after_reset got cyc=%0d acc=%0d want cyc=2 acc=10", cyc, sx11(bus.rom_acc));
        end
    endtask

    initial begin
        bus.instr     = 21'd0;
        bus.in_data   = 44'd0;
        bus.in_valid  = 4'b0000;
        bus.out_ready = 4'b0000;
        reset         = 1'b0;
        test_reset();
        test_basic();
        test_saturate();
        test_random();
        test_read();
        test_write();
        test_swap();
        test_jump_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
